// File: rtl/sync_fifo_pkg.sv
// Shared defaults and a sizing helper for the synchronous FIFO.
package sync_fifo_pkg;
    localparam int WIDTH_DEF      = 8;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int AF_THRESH_DEF  = 12;

    function automatic int depth_of(input int depth_log2);
        return 1 << depth_log2;
    endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if #(
    parameter int WIDTH      = sync_fifo_pkg::WIDTH_DEF,
    parameter int DEPTH_LOG2 = sync_fifo_pkg::DEPTH_LOG2_DEF
);
    logic                  wr_en;
    logic [WIDTH-1:0]      din;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [WIDTH-1:0]      dout;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;

    modport master (
        output wr_en, din, rd_en,
        input  full, almost_full, dout, empty, level, overflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, almost_full, dout, empty, level, overflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one read port with registered data.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    localparam int DEPTH = depth_of(DEPTH_LOG2);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately left out of reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, flag, level and sticky-overflow control around
// a registered-output dual-port RAM.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave bus
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] level;
    logic          full, empty;
    logic          wr_acc, rd_acc;

    // Flags depend only on registered pointers, never on this cycle's requests.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level  = wr_ptr_q - rd_ptr_q;

    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (bus.wr_en && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (bus.din),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (bus.dout)
    );

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.level       = level;
    assign bus.almost_full = (level >= AF_LVL);
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized bench for sync_fifo against a queue-based model.
module tb_sync_fifo;
    localparam int WIDTH = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) bus ();

    sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .AF_THRESH(AFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] q[$];
    logic [7:0] dout_m = 8'h00;
    logic       ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AFT));
        chk("dout", 32'(bus.dout), 32'(dout_m));
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
    endtask

    // Called at a negedge; applies one clock of requests and checks after it.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
        bit wacc, racc;
        bus.wr_en = wr;
        bus.din   = d;
        bus.rd_en = rd;
        @(posedge clk);
        wacc = wr && (q.size() < DEPTH);
        racc = rd && (q.size() > 0);
        if (wr && q.size() == DEPTH) ovf_m = 1'b1;
        if (racc) dout_m = q.pop_front();
        if (wacc) q.push_back(d);
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_model();
        q.delete();
        dout_m = 8'h00;
        ovf_m  = 1'b0;
    endtask

    initial begin
        int sent;
        int wprob;
        bus.wr_en = 1'b0;
        bus.din   = '0;
        bus.rd_en = 1'b0;

        // Reset state
        @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // Fill 0x00..0x0F, then overflow attempt with 0xAA
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hAB, 1'b1);   // full blocks write even with a read
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1);

        // Reads while empty: everything must hold
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous read/write at level 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);

        // Write while empty with a read: no fall-through
        cycle(1'b1, 8'h5A, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Reset asserted mid-cycle with words stored
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Randomized traffic: reader at rate 0.5, writer rate varies, never overfills
        sent  = 0;
        wprob = 5;
        for (int n = 0; n < 20000 && sent < 1000; n++) begin
            logic wr, rd;
            logic [7:0] d;
            if (n % 200 == 0) wprob = int'($urandom_range(1, 9));
            wr = (int'($urandom_range(0, 9)) < wprob) && (q.size() < DEPTH);
            rd = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (wr) sent++;
            cycle(wr, d, rd);
        end
        for (int n = 0; n < 200 && q.size() > 0; n++) cycle(1'b0, 8'h00, 1'b1);
        chk("rand_words_sent", 32'(sent), 32'd1000);
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_no_overflow", 32'(bus.overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
